// File: rtl/plot_pkg.sv
// Shared constants and types for the pixel plot receiver.
// Screen geometry, colour names, receiver states and the buffered pixel layout.
package plot_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int ADDR_W   = 15;
    localparam int PIXEL_W  = 18;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] BLUE  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CLEAR
    } state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous show-ahead FIFO holding accepted pixels until they are written.
// data_o always presents the oldest entry; a pop consumes it at the next edge.
module plot_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = plot_pkg::PIXEL_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign data_o  = mem_q[rdPtr_q];

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // A simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/plot_receiver.sv
// Accepts pixel plots into a FIFO and turns them into framebuffer writes; also
// performs full-screen clears after draining any pixels still buffered.
module plot_receiver #(
    parameter int SCREEN_W   = plot_pkg::SCREEN_W,
    parameter int SCREEN_H   = plot_pkg::SCREEN_H,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        plot_valid,
    output logic        plot_ready,
    input  logic [7:0]  plot_x,
    input  logic [6:0]  plot_y,
    input  logic [2:0]  plot_colour,
    input  logic        clear_req,
    input  logic [2:0]  clear_colour,
    output logic        busy,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_wdata,
    output logic [7:0]  dropped
);

    import plot_pkg::*;

    localparam logic [14:0] LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);

    state_t      state_q;
    state_t      state_d;
    logic        fifoFull;
    logic        fifoEmpty;
    logic        push;
    logic        pop;
    pixel_t      fifoDout;
    pixel_t      pix_q;
    logic        pixValid_q;
    logic        pixInRange;
    logic [14:0] pixAddr;
    logic [2:0]  clrColour_q;
    logic [14:0] clrAddr_q;
    logic        fbWe_q;
    logic [14:0] fbAddr_q;
    logic [2:0]  fbWdata_q;
    logic [7:0]  dropped_q;

    assign plot_ready = !fifoFull && (state_q == ST_IDLE) && !reset;
    assign push       = plot_valid && plot_ready;
    assign pop        = !fifoEmpty && (state_q != ST_CLEAR);
    assign busy       = (state_q == ST_DRAIN) || (state_q == ST_CLEAR);

    assign fb_we    = fbWe_q;
    assign fb_addr  = fbAddr_q;
    assign fb_wdata = fbWdata_q;
    assign dropped  = dropped_q;

    plot_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIXEL_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({plot_x, plot_y, plot_colour}),
        .data_o  (fifoDout),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign pixInRange = (32'(pix_q.x) < SCREEN_W) && (32'(pix_q.y) < SCREEN_H);

    // At the standard 160-pixel width, y*160 is built from two shifts.
    generate
        if (SCREEN_W == 160) begin : g_addr_shift
            assign pixAddr = {1'b0, pix_q.y, 7'b0} + {3'b0, pix_q.y, 5'b0} + {7'b0, pix_q.x};
        end else begin : g_addr_generic
            assign pixAddr = 15'(32'(pix_q.y) * SCREEN_W + 32'(pix_q.x));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifoEmpty) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clrAddr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The popped pixel sits in pix_q for one cycle before it becomes a write,
    // which keeps the address adder off the FIFO read path.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pixValid_q  <= 1'b0;
            pix_q       <= '0;
            clrColour_q <= BLACK;
            clrAddr_q   <= '0;
            fbWe_q      <= 1'b0;
            fbAddr_q    <= '0;
            fbWdata_q   <= '0;
            dropped_q   <= '0;
        end else begin
            state_q    <= state_d;
            pixValid_q <= pop;
            fbWe_q     <= 1'b0;
            if (pop) begin
                pix_q <= fifoDout;
            end
            if ((state_q == ST_IDLE) && clear_req) begin
                clrColour_q <= clear_colour;
            end
            if (state_q == ST_CLEAR) begin
                fbWe_q    <= 1'b1;
                fbAddr_q  <= clrAddr_q;
                fbWdata_q <= clrColour_q;
                clrAddr_q <= (clrAddr_q == LAST_ADDR) ? '0 : clrAddr_q + 1'b1;
            end else if (pixValid_q) begin
                if (pixInRange) begin
                    fbWe_q    <= 1'b1;
                    fbAddr_q  <= pixAddr;
                    fbWdata_q <= pix_q.colour;
                end else if (dropped_q != 8'hFF) begin
                    dropped_q <= dropped_q + 1'b1;
                end
            end
        end
    end

endmodule
